weight_rom_arbiter: RTL and testbench
=====================================

# weight_rom_arbiter

Round-robin burst-read scheduler that shares one combinational weight ROM (signed 8-bit words, N entries, address-in / data-out) among several requesters such as the tree-node evaluators and FFT twiddle loaders. Each requester asks for a contiguous burst (base, length). The block grants one requester at a time, drives the ROM address sequentially and returns registered data tagged with the requester ID. It sits between the ROM instance and its consumers; it is the only driver of the ROM address.

## Interface
- IDW, 2: requester ID width; NREQ = 2**IDW requesters.
- N, 1024: ROM depth; valid addresses are 0..N-1.
- LW, 6: burst length field width; len = 0 encodes 2**LW beats (64).
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester level request; held until the matching gnt bit is seen.
- base  in  NREQ*32  per-requester start address; slice i = bits [32*i+31 : 32*i].
- len  in  NREQ*LW  per-requester burst length; slice i = bits [LW*i+LW-1 : LW*i].
- gnt  out  NREQ  one-hot, one-cycle pulse marking the start of the granted burst.
- busy  out  1  high while a burst is issuing or draining.
- err  out  1  one-cycle pulse when the granted base is >= N; the burst is dropped.
- mem_adr  out  32  ROM address.
- mem_data  in  8 signed  ROM read data; combinational from mem_adr.
- rd_data  out  8 signed  registered ROM word.
- rd_valid  out  1  rd_data valid.
- rd_last  out  1  final beat of the burst; coincides with rd_valid.
- rd_id  out  IDW  requester index owning rd_data.

## Operation
- FSM has three states: IDLE, ISSUE, DRAIN.
- IDLE, with req != 0:
  - Select the winner from a rotating priority order starting at last_served+1 (mod NREQ).
  - Capture the winner's base, len and ID. Go to ISSUE.
- IDLE, with req == 0: stay in IDLE. mem_adr = 0.
- ISSUE:
  - gnt[id] = 1 in the first ISSUE cycle only. busy = 1.
  - mem_adr = current address; rd_data <= mem_data at each edge.
  - Beat counter counts 0..L-1, where L = len, or 64 when len = 0.
  - Address increment: address = address + 1, wrapping to 0 when it reaches N-1.
  - After beat L-1 is issued, go to DRAIN. last_served <= id.
- DRAIN:
  - The final rd_valid/rd_last beat appears. busy = 1. mem_adr = 0.
  - Next state is IDLE.
- Error case: a granted base >= N gives gnt and err in the same cycle. No beats are produced, no rd_valid appears, and last_served still advances. The FSM goes ISSUE -> IDLE after one cycle.
- Requests that arrive during ISSUE or DRAIN wait. A req dropped before its grant is simply lost; no state is kept per requester.
- base and len are sampled only in the arbitration cycle. Later changes have no effect on a burst in flight.
- Reset state:
  - FSM in IDLE. last_served = NREQ-1, so requester 0 wins first.
  - All outputs are 0: gnt, busy, err, mem_adr, rd_data, rd_valid, rd_last, rd_id.
- Reset mid-burst aborts the burst immediately. Outputs are 0 in the next cycle and no rd_last is emitted.

## Timing
- Cycle t: IDLE sees req.
- t+1: gnt pulses and mem_adr = base.
- Beat k: address on mem_adr in cycle t+1+k; rd_data/rd_valid in cycle t+2+k.
- rd_last occurs in cycle t+L+1, during DRAIN.
- The earliest next gnt is at t+L+3, so back-to-back grants are spaced L+2 cycles apart.
- The ROM read is combinational, so mem_adr to rd_data latency is exactly 1 cycle.
- rd_id is constant across a burst.

## Configuration
- WEIGHT_ARB_FIXED_PRIO_EN defined: fixed priority; the lowest requester index always wins and last_served is unused.
- WEIGHT_ARB_FIXED_PRIO_EN undefined (default): round-robin as specified above.
- All other behaviour and timing are identical in both builds.

## Test plan
All tests use a ROM preloaded with MEMO[k] = k mod 256 (8-bit two's complement).
- Single burst: req0, base=10, len=4 at t=0 -> gnt=0001 at t=1; mem_adr 10,11,12,13 in cycles 1-4; rd_data 10,11,12,13 in cycles 2-5; rd_last at 5; rd_id=0; busy high 1-5.
- All four requesters, len=1, held from t=0 -> grants in order 0,1,2,3 at t=1,4,7,10; each delivers exactly one beat with rd_last and the matching rd_id.
- Wrap-around: base=1022, len=4 -> mem_adr 1022,1023,0,1; rd_data -2,-1,0,1.
- Fairness: req0 and req2 held continuously, len=2 -> grants alternate 0,2,0,2, each spaced 4 cycles. With WEIGHT_ARB_FIXED_PRIO_EN defined, every grant goes to 0.
- Error and len=0: base=1024 -> gnt plus err in the same cycle, no rd_valid, back to IDLE in 1 cycle. base=0, len=0 -> 64 beats, values 0..63.
- Reset mid-burst: rst at beat 2 of a base=100, len=8 burst -> next cycle all outputs 0, no rd_last; req0 and req1 then pending -> requester 0 is granted first.

Source files
------------

// File: rtl/weight_rom_arbiter.sv
// Round-robin burst-read scheduler sharing one combinational weight ROM.
// Define WEIGHT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module weight_rom_arbiter #(
   parameter int IDW = 2,
   parameter int N   = 1024,
   parameter int LW  = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [(1<<IDW)-1:0]     req,
   input  logic [(32<<IDW)-1:0]    base,
   input  logic [(LW<<IDW)-1:0]    len,
   output logic [(1<<IDW)-1:0]     gnt,
   output logic                    busy,
   output logic                    err,
   output logic [31:0]             mem_adr,
   input  logic signed [7:0]       mem_data,
   output logic signed [7:0]       rd_data,
   output logic                    rd_valid,
   output logic                    rd_last,
   output logic [IDW-1:0]          rd_id
);

   localparam int NREQ = 1 << IDW;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [31:0]       addr_q, addr_d;
   logic [LW-1:0]     len_q, len_d;
   logic [LW-1:0]     cnt_q, cnt_d;
   logic              first_q, first_d;
   logic [IDW-1:0]    win;
   logic              issue, oob, last_beat;

   logic signed [7:0] rd_data_q;
   logic              rd_valid_q, rd_last_q;
   logic [IDW-1:0]    rd_id_q;

   assign issue     = (state_q == S_ISSUE);
   assign oob       = issue && first_q && (addr_q >= 32'(N));
   // len = 0 means 2**LW beats: len-1 wraps to the all-ones count
   assign last_beat = (cnt_q == len_q - LW'(1));

`ifdef WEIGHT_ARB_FIXED_PRIO_EN
   always_comb begin
      win = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) win = IDW'(i);
      end
   end
`else
   logic [IDW-1:0] last_q, idx;

   // scan from lowest to highest priority so the closest one wins
   always_comb begin
      win = '0;
      idx = '0;
      for (int i = NREQ; i >= 1; i--) begin
         idx = last_q + IDW'(i);
         if (req[idx]) win = idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= IDW'(NREQ - 1);
      end else if (issue && (oob || last_beat)) begin
         last_q <= id_q;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      first_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               id_d    = win;
               addr_d  = base[32*int'(win) +: 32];
               len_d   = len[LW*int'(win) +: LW];
               cnt_d   = '0;
               first_d = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (oob) begin
               state_d = S_IDLE;
            end else begin
               addr_d = (addr_q == 32'(N - 1)) ? 32'd0 : addr_q + 32'd1;
               cnt_d  = cnt_q + LW'(1);
               if (last_beat) state_d = S_DRAIN;
            end
         end
         S_DRAIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         first_q    <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_id_q    <= '0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         first_q    <= first_d;
         rd_valid_q <= issue && !oob;
         rd_last_q  <= issue && !oob && last_beat;
         if (issue && !oob) begin
            rd_data_q <= mem_data;
            rd_id_q   <= id_q;
         end
      end
   end

   assign gnt      = (issue && first_q) ? (NREQ'(1) << id_q) : '0;
   assign busy     = (state_q != S_IDLE);
   assign err      = oob;
   assign mem_adr  = (issue && !oob) ? addr_q : 32'd0;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_last  = rd_last_q;
   assign rd_id    = rd_id_q;

endmodule

// File: tb/tb_weight_rom_arbiter.sv
// Directed bench for weight_rom_arbiter (default round-robin build).
// ROM model holds k mod 256 at address k.
module tb_weight_rom_arbiter;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        req;
   logic [127:0]      base;
   logic [23:0]       len;
   logic [3:0]        gnt;
   logic              busy, err;
   logic [31:0]       mem_adr;
   logic signed [7:0] mem_data;
   logic signed [7:0] rd_data;
   logic              rd_valid, rd_last;
   logic [1:0]        rd_id;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign mem_data = (mem_adr < 32'd1024) ? mem_adr[7:0] : 8'sd0;

   weight_rom_arbiter #(.IDW(2), .N(1024), .LW(6)) dut (
      .clk(clk), .rst(rst), .req(req), .base(base), .len(len),
      .gnt(gnt), .busy(busy), .err(err), .mem_adr(mem_adr),
      .mem_data(mem_data), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_last(rd_last), .rd_id(rd_id)
   );

   typedef struct {
      logic [3:0]  rq;
      int          b;
      logic [5:0]  l;
      int          id;
      int          beats;
      bit          e;
      int          first;
      int          last;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input int act, input int exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int romv(input int a);
      int d;
      d = a % 256;
      return (d > 127) ? d - 256 : d;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      req  = '0;
      repeat (2) @(negedge clk);
      rst  = 1'b0;
   endtask

   task automatic run_vec(input int n, input vec_t v);
      int L, ex;
      string p;
      p = $sformatf("v%0d", n);
      L = v.beats;
      @(negedge clk);
      req  = v.rq;
      base = {4{v.b[31:0]}};
      len  = {4{v.l}};
      @(posedge clk); #1;
      req  = '0;
      base = '1;
      len  = {4{6'd1}};
      chk({p, " gnt"}, int'(gnt), 1 << v.id);
      chk({p, " err"}, int'(err), int'(v.e));
      chk({p, " busy"}, int'(busy), 1);
      if (v.e) begin
         chk({p, " err adr"}, int'(mem_adr), 0);
         @(posedge clk); #1;
         chk({p, " err idle"}, int'(busy), 0);
         chk({p, " err novalid"}, int'(rd_valid), 0);
         chk({p, " err pulse"}, int'(err), 0);
      end else begin
         for (int c = 1; c <= L + 1; c++) begin
            if (c > 1) begin
               @(posedge clk); #1;
               chk({p, " gnt off"}, int'(gnt), 0);
            end
            chk({p, " busy"}, int'(busy), 1);
            if (c <= L) chk({p, " adr"}, int'(mem_adr), (v.b + c - 1) % 1024);
            else        chk({p, " drain adr"}, int'(mem_adr), 0);
            if (c >= 2) begin
               if (c == L + 1)  ex = v.last;
               else if (c == 2) ex = v.first;
               else             ex = romv(v.b + c - 2);
               chk({p, " valid"}, int'(rd_valid), 1);
               chk({p, " data"}, int'(rd_data), ex);
               chk({p, " last"}, int'(rd_last), int'(c == L + 1));
               chk({p, " id"}, int'(rd_id), v.id);
            end
         end
         @(posedge clk); #1;
         chk({p, " idle"}, int'(busy), 0);
         chk({p, " valid off"}, int'(rd_valid), 0);
      end
   endtask

   initial begin
      int eg, ev;
      vecs[0] = '{4'b0001, 10,   6'd4,  0, 4,  1'b0, 10,  13};
      vecs[1] = '{4'b0001, 1022, 6'd4,  0, 4,  1'b0, -2,  1};
      vecs[2] = '{4'b0101, 5,    6'd2,  2, 2,  1'b0, 5,   6};
      vecs[3] = '{4'b0101, 200,  6'd3,  0, 3,  1'b0, -56, -54};
      vecs[4] = '{4'b0010, 1024, 6'd4,  1, 0,  1'b1, 0,   0};
      vecs[5] = '{4'b1111, 0,    6'd0,  2, 64, 1'b0, 0,   63};
      vecs[6] = '{4'b1010, 1023, 6'd1,  3, 1,  1'b0, -1,  -1};
      vecs[7] = '{4'b0010, 300,  6'd63, 1, 63, 1'b0, 44,  106};

      rst  = 1'b1;
      req  = '0;
      base = '0;
      len  = '0;
      repeat (3) @(negedge clk);
      chk("rst gnt", int'(gnt), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst err", int'(err), 0);
      chk("rst adr", int'(mem_adr), 0);
      chk("rst data", int'(rd_data), 0);
      chk("rst valid", int'(rd_valid), 0);
      chk("rst last", int'(rd_last), 0);
      chk("rst id", int'(rd_id), 0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // four requesters, one beat each, rotating grants
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 4; i++) base[32*i +: 32] = 32'(100 * i + 7);
      len = {4{6'd1}};
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         eg = (c % 3 == 1 && c <= 10) ? (1 << (c / 3)) : 0;
         ev = (c % 3 == 2 && c <= 11) ? 1 : 0;
         chk("rr4 gnt", int'(gnt), eg);
         chk("rr4 valid", int'(rd_valid), ev);
         chk("rr4 last", int'(rd_last), ev);
         if (ev == 1) begin
            chk("rr4 id", int'(rd_id), c / 3);
            chk("rr4 data", int'(rd_data), romv(100 * (c / 3) + 7));
         end
         if (eg != 0) req = req & ~4'(eg);
      end

      // fairness between requesters 0 and 2
      do_reset();
      req  = 4'b0101;
      base = {4{32'd500}};
      len  = {4{6'd2}};
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk); #1;
         eg = (c % 4 != 1) ? 0 : (((c / 4) % 2 == 0) ? 1 : 4);
         chk("fair gnt", int'(gnt), eg);
      end
      req = '0;

      // reset in the middle of a burst
      do_reset();
      req  = 4'b0001;
      base = {4{32'd100}};
      len  = {4{6'd8}};
      @(posedge clk); #1;
      chk("mid gnt", int'(gnt), 1);
      repeat (2) @(posedge clk);
      #1;
      chk("mid beat2 adr", int'(mem_adr), 102);
      @(negedge clk);
      rst = 1'b1;
      req = 4'b0011;
      @(posedge clk); #1;
      chk("mid gnt0", int'(gnt), 0);
      chk("mid busy0", int'(busy), 0);
      chk("mid err0", int'(err), 0);
      chk("mid adr0", int'(mem_adr), 0);
      chk("mid data0", int'(rd_data), 0);
      chk("mid valid0", int'(rd_valid), 0);
      chk("mid last0", int'(rd_last), 0);
      chk("mid id0", int'(rd_id), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("mid regrant", int'(gnt), 1);
      chk("mid regrant adr", int'(mem_adr), 100);
      req = '0;
      repeat (12) @(posedge clk);
      #1;
      chk("final idle", int'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
